// File: rtl/mem_lsu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_lsu_if                                                      |
// | Function : Request/response and DRAM-port bundle for the mem_lsu unit.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface mem_lsu_if #(
    parameter int XLEN = 32
);
    localparam int c_NB = XLEN / 8;

    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_we_i;
    logic [1:0]      req_size_i;
    logic            req_unsigned_i;
    logic [XLEN-1:0] req_addr_i;
    logic [XLEN-1:0] req_wdata_i;
    logic            rsp_valid_o;
    logic [XLEN-1:0] rsp_rdata_o;
    logic            rsp_err_o;
    logic            dram_valid_o;
    logic            dram_ready_i;
    logic            dram_we_o;
    logic [XLEN-1:0] dram_addr_o;
    logic [c_NB-1:0] dram_byte_en_o;
    logic [XLEN-1:0] dram_wdata_o;
    logic            dram_rvalid_i;
    logic [XLEN-1:0] dram_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output dram_valid_o, dram_we_o, dram_addr_o, dram_byte_en_o, dram_wdata_o,
        input  dram_ready_i, dram_rvalid_i, dram_rdata_i
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  dram_valid_o, dram_we_o, dram_addr_o, dram_byte_en_o, dram_wdata_o,
        output dram_ready_i, dram_rvalid_i, dram_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_lsu                                                         |
// | Function : Load/store unit: lane alignment, load extension, misalign check |
// |            and variable-latency DRAM handshake. Optional response watchdog |
// |            enabled by defining MEM_LSU_TIMEOUT_EN.                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mem_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  wire      clk_i,
    input  wire      rst_i,
    mem_lsu_if.slave bus
);
    localparam int c_NB  = XLEN / 8;
    localparam int c_OFS = $clog2(c_NB);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_ready;
    logic            r_rsp_valid;
    logic            r_err;
    logic [XLEN-1:0] r_rdata;
    logic            r_dvalid;
    logic            r_we;
    logic [XLEN-1:0] r_daddr;
    logic [c_NB-1:0] r_be;
    logic [XLEN-1:0] r_dwdata;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic [c_OFS-1:0] r_ofs;

    logic [c_OFS-1:0] w_ofs;
    logic [c_OFS-1:0] w_amask;
    logic [3:0]       w_nbytes;
    logic             w_mis;
    logic [c_NB-1:0]  w_be;
    logic [XLEN-1:0]  w_wmask;
    logic [XLEN-1:0]  w_wdata;
    logic [3:0]       w_rnbytes;
    logic [XLEN-1:0]  w_rsh;
    logic [XLEN-1:0]  w_ext;
    logic             w_fill;
    logic             w_tmo;

    assign w_ofs     = bus.req_addr_i[c_OFS-1:0];
    assign w_nbytes  = 4'd1 << bus.req_size_i;
    assign w_rnbytes = 4'd1 << r_size;

    always_comb begin
        w_amask = '0;
        case (bus.req_size_i)
            2'd0:    w_amask = '0;
            2'd1:    w_amask = c_OFS'(1);
            2'd2:    w_amask = c_OFS'(3);
            default: w_amask = c_OFS'(7);
        endcase
    end

    // Doubleword is only a legal size on a 64-bit datapath.
    assign w_mis = (|(w_ofs & w_amask)) || ((c_NB == 4) && (bus.req_size_i == 2'd3));

    always_comb begin
        w_be    = '0;
        w_wmask = '0;
        for (int i = 0; i < c_NB; i++) begin
            if (i < int'(w_nbytes)) begin
                w_wmask[8*i +: 8] = 8'hFF;
            end
            if ((i >= int'(w_ofs)) && (i < int'(w_ofs) + int'(w_nbytes))) begin
                w_be[i] = 1'b1;
            end
        end
    end

    assign w_wdata = (bus.req_wdata_i & w_wmask) << {w_ofs, 3'b000};

    assign w_rsh = bus.dram_rdata_i >> {r_ofs, 3'b000};

    always_comb begin
        w_fill = 1'b0;
        w_ext  = '0;
        for (int i = 0; i < c_NB; i++) begin
            if (i == int'(w_rnbytes) - 1) begin
                w_fill = w_rsh[8*i+7];
            end
        end
        if (r_unsigned) begin
            w_fill = 1'b0;
        end
        for (int i = 0; i < c_NB; i++) begin
            w_ext[8*i +: 8] = (i < int'(w_rnbytes)) ? w_rsh[8*i +: 8] : {8{w_fill}};
        end
    end

`ifdef MEM_LSU_TIMEOUT_EN
    localparam int c_CW_RAW = $clog2(TIMEOUT + 1);
    localparam int c_CW     = (c_CW_RAW < 8) ? 8 : ((c_CW_RAW > 32) ? 32 : c_CW_RAW);
    localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'(TIMEOUT - 1);

    logic [c_CW-1:0] r_tmo;

    // The REQ->WAIT handshake restarts the count so WAIT gets a full budget.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmo <= '0;
        end else if ((r_state == S_IDLE) || (r_state == S_DONE) ||
                     ((r_state == S_REQ) && bus.dram_ready_i)) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_tmo = (r_tmo == c_TMO_LAST);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_tmo            = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_dvalid    <= 1'b0;
            r_we        <= 1'b0;
            r_daddr     <= '0;
            r_be        <= '0;
            r_dwdata    <= '0;
            r_size      <= 2'd0;
            r_unsigned  <= 1'b0;
            r_ofs       <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        r_ready    <= 1'b0;
                        r_err      <= w_mis;
                        r_we       <= bus.req_we_i;
                        r_size     <= bus.req_size_i;
                        r_unsigned <= bus.req_unsigned_i;
                        r_ofs      <= w_ofs;
                        if (w_mis) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_dvalid <= 1'b1;
                            r_daddr  <= {bus.req_addr_i[XLEN-1:c_OFS], {c_OFS{1'b0}}};
                            r_be     <= w_be;
                            r_dwdata <= w_wdata;
                            r_state  <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.dram_ready_i) begin
                        r_dvalid <= 1'b0;
                        if (r_we) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else if (w_tmo) begin
                        r_dvalid    <= 1'b0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_WAIT: begin
                    if (bus.dram_rvalid_i) begin
                        r_rdata     <= w_ext;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_tmo) begin
                        r_err       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o    = r_ready;
    assign bus.rsp_valid_o    = r_rsp_valid;
    assign bus.rsp_rdata_o    = r_rdata;
    assign bus.rsp_err_o      = r_err;
    assign bus.dram_valid_o   = r_dvalid;
    assign bus.dram_we_o      = r_we;
    assign bus.dram_addr_o    = r_daddr;
    assign bus.dram_byte_en_o = r_be;
    assign bus.dram_wdata_o   = r_dwdata;
endmodule
`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Parametrised load/store unit between the hxd32 execute stage and the DRAM port.
- Generalises the fixed byte-enable decode to any XLEN, with address-offset lane shifting, write-data lane alignment and load sign/zero extension.
- Adds a valid/ready request handshake and a response wait state machine for variable-latency DRAM.
- Detects misaligned accesses and completes them with an error flag, without issuing any DRAM access.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64. NB = XLEN/8 byte lanes, OFS = log2(NB) offset bits.
- TIMEOUT, 255, response watchdog limit in cycles; used only with MEM_LSU_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- req_valid_i  in  1  access request
- req_ready_o  out  1  unit idle, can accept a request
- req_we_i  in  1  1=store, 0=load
- req_size_i  in  2  00=B, 01=H, 10=W, 11=D (D legal only when XLEN=64)
- req_unsigned_i  in  1  load zero-extends when 1
- req_addr_i  in  XLEN  byte address
- req_wdata_i  in  XLEN  store data, LSB-justified
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  XLEN  extended load data
- rsp_err_o  out  1  misaligned (or timeout) on this completion
- dram_valid_o  out  1  DRAM request valid
- dram_ready_i  in  1  DRAM accepts request
- dram_we_o  out  1  DRAM write
- dram_addr_o  out  XLEN  lane-aligned address (low OFS bits zero)
- dram_byte_en_o  out  NB  byte lane enables
- dram_wdata_o  out  XLEN  lane-shifted store data
- dram_rvalid_i  in  1  read data valid
- dram_rdata_i  in  XLEN  full-lane read data

Behaviour:
- Reset: all outputs 0 except req_ready_o; state IDLE; req_ready_o=1 once rst_i is deasserted. Reset mid-transaction aborts immediately: dram_valid_o drops asynchronously and no rsp_valid_o is produced.
- Byte enable: nbytes = 1<<size; byte_en = ((1<<nbytes)-1) << addr[OFS-1:0]. wdata is shifted left by 8*offset. Unused lanes of dram_wdata_o are 0.
- Misaligned when addr modulo nbytes != 0, or when size=11 with XLEN=32.
- IDLE: req_ready_o=1. On req_valid_i, latch all request fields.
  - If misaligned: go to DONE with err=1.
  - Otherwise: go to REQ.
- REQ: dram_valid_o=1. All dram_* outputs are registered and held stable until dram_ready_i.
  - On handshake with a store: go to DONE.
  - On handshake with a load: go to WAIT.
- WAIT: sample dram_rvalid_i only in this state. On rvalid:
  - shift rdata right by 8*offset;
  - truncate to nbytes;
  - sign-extend from the top byte unless unsigned (D ignores unsigned);
  - register the result into rsp_rdata_o and go to DONE.
- DONE: rsp_valid_o=1 for exactly one cycle, then return to IDLE. req_ready_o=0 in every state except IDLE, so back-to-back requests cost one idle cycle.
- rsp_rdata_o updates only on successful loads and holds otherwise. rsp_err_o is valid with rsp_valid_o and cleared on the next accept.
- Latency with zero-wait DRAM:
  - store: accept at cycle 0, rsp_valid_o at cycle 2;
  - load with rvalid at cycle 2: rsp_valid_o at cycle 3;
  - misaligned: rsp_valid_o at cycle 1.
- dram_rvalid_i outside WAIT is ignored. dram_ready_i outside REQ is ignored.

Optional Feature:
- MEM_LSU_TIMEOUT_EN defined:
  - an 8..32-bit counter clears on entry to REQ or WAIT and counts cycles while in either state;
  - reaching TIMEOUT forces DONE with rsp_err_o=1, drops dram_valid_o, and leaves rsp_rdata_o unchanged.
- Undefined: no counter; the unit waits indefinitely in REQ/WAIT.

Test Plan:
- XLEN=32, SB addr 0x1003, wdata 0x000000A5, ready=1 -> byte_en 4'b1000, dram_addr 0x1000, wdata 0xA5000000, rsp_valid_o at cycle 2, err 0.
- LH signed addr 0x2002, rdata 0x80FF1234 -> rsp_rdata_o 0xFFFF80FF; same access as LHU -> 0x000080FF.
- LW addr 0x3002 -> rsp_valid_o at cycle 1, rsp_err_o=1, dram_valid_o never asserted; SD with XLEN=32 -> same response.
- SW with dram_ready_i low for 5 cycles -> dram_valid/addr/byte_en 4'b1111/wdata stable for all 6 cycles, one rsp pulse after ready.
- XLEN=64, LD addr 0x8 with rdata 0x8000000000000001 -> byte_en 8'hFF, rsp_rdata_o equal to rdata; rst_i pulsed while in WAIT -> no rsp, req_ready_o=1 after release.
- MEM_LSU_TIMEOUT_EN, TIMEOUT=16, LW with rvalid never asserted -> rsp_valid_o with rsp_err_o=1 exactly 16 cycles after WAIT entry.
